// File: rtl/conv_pkg.sv
// Shared definitions for the CONV datapath MAC array: default widths,
// the wavefront tag carried alongside each beat, and sign/clamp helpers.
package conv_pkg;

  localparam int DW_DEF     = 8;
  localparam int CW_DEF     = 19;
  localparam int OW_DEF     = 26;
  localparam int ROW_DEF    = 7;
  localparam int COLUMN_DEF = 7;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  // Widths up to 64 bits; callers zero-extend into v and truncate the result.
  function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
    logic signed [63:0] t;
    t = signed'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] relu(input logic [63:0] v, input int w,
                                              input logic en);
    logic signed [63:0] t;
    t = sext(v, w);
    return (en && t[63]) ? '0 : t;
  endfunction

endpackage

// File: rtl/mac_row_en.sv
// One systolic row: COLUMN processing elements sharing one activation,
// each adding its signed product onto the partial sum from the row above.
module mac_row_en
  import conv_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int CW     = CW_DEF,
  parameter int COLUMN = COLUMN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   w_load,
  input  logic [COLUMN*DW-1:0]   w_data,
  input  logic [DW-1:0]          x_in,
  input  logic [COLUMN*CW-1:0]   p_in,
  output logic [COLUMN*CW-1:0]   p_out
);

  logic [COLUMN*DW-1:0] w_q, w_d;
  logic [COLUMN*CW-1:0] p_q, p_d;
  logic signed [2*DW-1:0] prod;

  // Weight loads are gated upstream by w_busy, not by the pipeline enable.
  always_comb begin
    w_d = w_load ? w_data : w_q;
  end

  always_comb begin
    p_d  = p_q;
    prod = '0;
    if (en) begin
      for (int c = 0; c < COLUMN; c++) begin
        prod = (2*DW)'(signed'(x_in)) * (2*DW)'(signed'(w_q[c*DW +: DW]));
        p_d[c*CW +: CW] = p_in[c*CW +: CW] + CW'(prod);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      p_q <= '0;
    end else begin
      w_q <= w_d;
      p_q <= p_d;
    end
  end

  assign p_out = p_q;

endmodule

// File: rtl/mac_array_acc.sv
// ROW x COLUMN systolic MAC array with input skew, wavefront tags and
// per-column channel-group accumulators feeding a held output register.
module mac_array_acc
  import conv_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int CW     = CW_DEF,
  parameter int OW     = OW_DEF,
  parameter int ROW    = ROW_DEF,
  parameter int COLUMN = COLUMN_DEF,
  parameter int RELU   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ROW*DW-1:0]      s_data,
  input  logic [COLUMN*CW-1:0]   s_ci,
  input  logic                   s_first,
  input  logic                   s_last,
  input  logic [COLUMN*DW-1:0]   w_data,
  input  logic [ROW-1:0]         w_load,
  output logic                   w_busy,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COLUMN*OW-1:0]   m_data
);

  logic en;
  logic accept;
  logic m_valid_q, m_valid_d;
  logic grp_open_q, grp_open_d;
  logic [COLUMN*OW-1:0] acc_q, acc_d;
  logic [COLUMN*OW-1:0] m_data_q, m_data_d;
  logic [OW-1:0] sum;
  tag_t res;
  tag_t tag_q [ROW];
  tag_t tag_d [ROW];
  logic [DW-1:0] x_row [ROW];
  logic [COLUMN*CW-1:0] p_chain [ROW+1];

  // A pending unaccepted result freezes everything upstream of it.
  assign en      = !(m_valid_q && !m_ready);
  assign s_ready = en;
  assign accept  = s_valid && en;

  assign p_chain[0] = s_ci;

  genvar r;
  generate
    for (r = 0; r < ROW; r++) begin : g_row
      if (r == 0) begin : g_noskew
        assign x_row[r] = s_data[DW-1:0];
      end else begin : g_skew
        logic [DW-1:0] sk_q [r];
        logic [DW-1:0] sk_d [r];

        always_comb begin
          for (int k = 0; k < r; k++) sk_d[k] = sk_q[k];
          if (en) begin
            sk_d[0] = s_data[r*DW +: DW];
            for (int k = 1; k < r; k++) sk_d[k] = sk_q[k-1];
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < r; k++) sk_q[k] <= '0;
          end else begin
            for (int k = 0; k < r; k++) sk_q[k] <= sk_d[k];
          end
        end

        assign x_row[r] = sk_q[r-1];
      end

      mac_row_en #(
        .DW     (DW),
        .CW     (CW),
        .COLUMN (COLUMN)
      ) u_row (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .w_load (w_load[r] && !w_busy),
        .w_data (w_data),
        .x_in   (x_row[r]),
        .p_in   (p_chain[r]),
        .p_out  (p_chain[r+1])
      );
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < ROW; i++) tag_d[i] = tag_q[i];
    if (en) begin
      tag_d[0] = '{vld: accept, first: s_first, last: s_last};
      for (int i = 1; i < ROW; i++) tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    w_busy = accept;
    for (int i = 0; i < ROW; i++) w_busy = w_busy | tag_q[i].vld;
  end

  // The oldest tag lines up with the finished wavefront leaving the last row.
  always_comb begin
    acc_d      = acc_q;
    grp_open_d = grp_open_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    res        = tag_q[ROW-1];
    sum        = '0;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (en && res.vld) begin
      for (int c = 0; c < COLUMN; c++) begin
        if (res.first || !grp_open_q)
          sum = OW'(sext(64'(p_chain[ROW][c*CW +: CW]), CW));
        else
          sum = acc_q[c*OW +: OW] + OW'(sext(64'(p_chain[ROW][c*CW +: CW]), CW));
        acc_d[c*OW +: OW] = sum;
        if (res.last) m_data_d[c*OW +: OW] = OW'(relu(64'(sum), OW, RELU != 0));
      end
      grp_open_d = !res.last;
      if (res.last) m_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROW; i++) tag_q[i] <= '0;
      acc_q      <= '0;
      grp_open_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < ROW; i++) tag_q[i] <= tag_d[i];
      acc_q      <= acc_d;
      grp_open_q <= grp_open_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_mac_array_acc.sv
// Directed bench for mac_array_acc: a 2x2 array without clamp (narrow
// accumulator for wrap checks) and a 2x2 array with clamp, driven in lockstep.
module tb_mac_array_acc;

  localparam int DW  = 8;
  localparam int ROW = 2;
  localparam int COL = 2;
  localparam int CW1 = 16;
  localparam int OW1 = 19;
  localparam int CW2 = 19;
  localparam int OW2 = 26;

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid, s_first, s_last, m_ready;
  logic [ROW*DW-1:0] s_data;
  logic [COL*DW-1:0] w_data;
  logic [ROW-1:0]    w_load;
  logic [COL*CW1-1:0] s_ci1;
  logic [COL*CW2-1:0] s_ci2;
  logic s_ready1, w_busy1, m_valid1;
  logic s_ready2, w_busy2, m_valid2;
  logic [COL*OW1-1:0] m_data1;
  logic [COL*OW2-1:0] m_data2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_array_acc #(.DW(DW), .CW(CW1), .OW(OW1), .ROW(ROW), .COLUMN(COL), .RELU(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_ci(s_ci1), .s_first(s_first), .s_last(s_last), .w_data(w_data), .w_load(w_load),
    .w_busy(w_busy1), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1));

  mac_array_acc #(.DW(DW), .CW(CW2), .OW(OW2), .ROW(ROW), .COLUMN(COL), .RELU(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_ci(s_ci2), .s_first(s_first), .s_last(s_last), .w_data(w_data), .w_load(w_load),
    .w_busy(w_busy2), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2));

  function automatic logic [COL*OW1-1:0] exp1(input int a, input int b);
    return {OW1'(b), OW1'(a)};
  endfunction

  function automatic logic [COL*OW2-1:0] exp2(input int a, input int b);
    return {OW2'(b), OW2'(a)};
  endfunction

  task automatic drive(input int x0, input int x1, input int ci0, input int ci1,
                       input bit first, input bit last);
    s_data  = {8'(x1), 8'(x0)};
    s_ci1   = {CW1'(ci1), CW1'(ci0)};
    s_ci2   = {CW2'(ci1), CW2'(ci0)};
    s_first = first;
    s_last  = last;
    s_valid = 1'b1;
  endtask

  task automatic send(input int x0, input int x1, input int ci0, input int ci1,
                      input bit first, input bit last);
    bit ok;
    ok = 1'b0;
    drive(x0, x1, ci0, ci1, first, last);
    for (int n = 0; n < 50 && !ok; n++) begin
      #1;
      ok = s_ready1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_first = 1'b0;
    s_last  = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL send_accept: got not accepted want accepted"); end
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (m_valid1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic load_weights(input logic [ROW-1:0] mask, input int c0, input int c1);
    w_data = {8'(c1), 8'(c0)};
    w_load = mask;
    @(posedge clk); #1;
    w_load = '0;
  endtask

  task automatic test_reset();
    bit seen;
    #2;
    tests++; if (s_ready1 !== 1'b1) begin fails++; $display("[TB] FAIL rst_s_ready: got %b want 1", s_ready1); end
    tests++; if (s_ready2 !== 1'b1) begin fails++; $display("[TB] FAIL rst_s_ready2: got %b want 1", s_ready2); end
    tests++; if (w_busy1 !== 1'b0) begin fails++; $display("[TB] FAIL rst_w_busy: got %b want 0", w_busy1); end
    tests++; if (w_busy2 !== 1'b0) begin fails++; $display("[TB] FAIL rst_w_busy2: got %b want 0", w_busy2); end
    tests++; if (m_valid1 !== 1'b0) begin fails++; $display("[TB] FAIL rst_m_valid: got %b want 0", m_valid1); end
    tests++; if (m_data1 !== '0) begin fails++; $display("[TB] FAIL rst_m_data: got %h want 0", m_data1); end
    tests++; if (m_data2 !== '0) begin fails++; $display("[TB] FAIL rst_m_data2: got %h want 0", m_data2); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    // zero weights after reset: the result is just the seed
    m_ready = 1'b1;
    send(5, 6, 3, 7, 1'b1, 1'b1);
    wait_valid(10, seen);
    tests++; if (!seen) begin fails++; $display("[TB] FAIL rst_zero_w_timeout: got no m_valid want m_valid"); end
    tests++; if (m_data1 !== exp1(3, 7)) begin fails++; $display("[TB] FAIL rst_zero_w: got %h want %h", m_data1, exp1(3, 7)); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    load_weights(2'b01, 1, 2);
    load_weights(2'b10, 3, 4);
    m_ready = 1'b0;
    send(5, 6, 0, 0, 1'b1, 1'b1);
    tests++; if (m_valid1 !== 1'b0) begin fails++; $display("[TB] FAIL single_early0: got %b want 0", m_valid1); end
    @(posedge clk); #1;
    tests++; if (m_valid1 !== 1'b0) begin fails++; $display("[TB] FAIL single_early1: got %b want 0", m_valid1); end
    @(posedge clk); #1;
    tests++; if (m_valid1 !== 1'b1) begin fails++; $display("[TB] FAIL single_latency: got %b want 1", m_valid1); end
    tests++; if (m_valid2 !== 1'b1) begin fails++; $display("[TB] FAIL single_latency2: got %b want 1", m_valid2); end
    tests++; if (m_data1 !== exp1(23, 34)) begin fails++; $display("[TB] FAIL single_data: got %h want %h", m_data1, exp1(23, 34)); end
    tests++; if (m_data2 !== exp2(23, 34)) begin fails++; $display("[TB] FAIL single_data2: got %h want %h", m_data2, exp2(23, 34)); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (m_valid1 !== 1'b1) begin fails++; $display("[TB] FAIL single_hold: got %b want 1", m_valid1); end
    tests++; if (s_ready1 !== 1'b0) begin fails++; $display("[TB] FAIL single_s_ready_low: got %b want 0", s_ready1); end
    m_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (m_valid1 !== 1'b0) begin fails++; $display("[TB] FAIL single_drop: got %b want 0", m_valid1); end
    tests++; if (s_ready1 !== 1'b1) begin fails++; $display("[TB] FAIL single_s_ready_back: got %b want 1", s_ready1); end
  endtask

  task automatic test_group();
    int nvalid;
    logic [COL*OW1-1:0] got;
    nvalid = 0;
    got = '0;
    m_ready = 1'b1;
    send(1, 1, 0, 0, 1'b1, 1'b0);
    send(2, 2, 0, 0, 1'b0, 1'b0);
    send(-1, -1, 0, 0, 1'b0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      if (m_valid1) begin nvalid++; got = m_data1; end
      @(posedge clk); #1;
    end
    tests++; if (nvalid != 1) begin fails++; $display("[TB] FAIL group_count: got %0d want 1", nvalid); end
    tests++; if (got !== exp1(8, 12)) begin fails++; $display("[TB] FAIL group_data: got %h want %h", got, exp1(8, 12)); end
  endtask

  task automatic test_stall();
    bit seen;
    m_ready = 1'b0;
    send(5, 6, 0, 0, 1'b1, 1'b1);
    send(1, 1, 0, 0, 1'b1, 1'b0);
    send(2, 2, 0, 0, 1'b0, 1'b0);
    tests++; if (m_valid1 !== 1'b1) begin fails++; $display("[TB] FAIL stall_first_valid: got %b want 1", m_valid1); end
    drive(3, 3, 0, 0, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) begin
      #1;
      tests++; if (s_ready1 !== 1'b0) begin fails++; $display("[TB] FAIL stall_s_ready: got %b want 0", s_ready1); end
      tests++; if (m_data1 !== exp1(23, 34)) begin fails++; $display("[TB] FAIL stall_hold: got %h want %h", m_data1, exp1(23, 34)); end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    #1;
    tests++; if (s_ready1 !== 1'b1) begin fails++; $display("[TB] FAIL stall_release: got %b want 1", s_ready1); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
    tests++; if (m_valid1 !== 1'b0) begin fails++; $display("[TB] FAIL stall_drop: got %b want 0", m_valid1); end
    wait_valid(10, seen);
    tests++; if (!seen) begin fails++; $display("[TB] FAIL stall_second_timeout: got no m_valid want m_valid"); end
    tests++; if (m_data1 !== exp1(24, 36)) begin fails++; $display("[TB] FAIL stall_second: got %h want %h", m_data1, exp1(24, 36)); end
    @(posedge clk); #1;
  endtask

  task automatic test_wload_busy();
    bit seen;
    m_ready = 1'b1;
    drive(5, 6, 0, 0, 1'b1, 1'b1);
    w_data = {8'd9, 8'd9};
    w_load = 2'b11;
    #1;
    tests++; if (w_busy1 !== 1'b1) begin fails++; $display("[TB] FAIL wl_busy_accept: got %b want 1", w_busy1); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
    #1;
    tests++; if (w_busy1 !== 1'b1) begin fails++; $display("[TB] FAIL wl_busy_flight: got %b want 1", w_busy1); end
    @(posedge clk); #1;
    w_load = '0;
    wait_valid(10, seen);
    tests++; if (!seen) begin fails++; $display("[TB] FAIL wl_old_timeout: got no m_valid want m_valid"); end
    tests++; if (m_data1 !== exp1(23, 34)) begin fails++; $display("[TB] FAIL wl_old_weights: got %h want %h", m_data1, exp1(23, 34)); end
    @(posedge clk); #1;
    tests++; if (w_busy1 !== 1'b0) begin fails++; $display("[TB] FAIL wl_idle: got %b want 0", w_busy1); end
    load_weights(2'b01, 10, 20);
    send(5, 6, 0, 0, 1'b1, 1'b1);
    wait_valid(10, seen);
    tests++; if (!seen) begin fails++; $display("[TB] FAIL wl_new_timeout: got no m_valid want m_valid"); end
    tests++; if (m_data1 !== exp1(68, 124)) begin fails++; $display("[TB] FAIL wl_new_weights: got %h want %h", m_data1, exp1(68, 124)); end
    @(posedge clk); #1;
    load_weights(2'b01, 1, 2);
  endtask

  task automatic test_relu_wrap();
    bit seen;
    int ci0;
    m_ready = 1'b1;
    send(-1, -2, 0, 0, 1'b1, 1'b1);
    wait_valid(10, seen);
    tests++; if (!seen) begin fails++; $display("[TB] FAIL relu_timeout: got no m_valid want m_valid"); end
    tests++; if (m_data1 !== exp1(-7, -10)) begin fails++; $display("[TB] FAIL relu_off_neg: got %h want %h", m_data1, exp1(-7, -10)); end
    tests++; if (m_data2 !== exp2(0, 0)) begin fails++; $display("[TB] FAIL relu_clamp: got %h want %h", m_data2, exp2(0, 0)); end
    @(posedge clk); #1;
    // seeds sum to 2^18-1 over nine beats, then one more pushes past the top
    for (int i = 0; i < 10; i++) begin
      ci0 = (i < 8) ? 32767 : ((i == 8) ? 7 : 1);
      send(0, 0, ci0, 1, i == 0, i == 9);
    end
    wait_valid(10, seen);
    tests++; if (!seen) begin fails++; $display("[TB] FAIL wrap_timeout: got no m_valid want m_valid"); end
    tests++; if (m_data1 !== exp1(-262144, 10)) begin fails++; $display("[TB] FAIL wrap_ow: got %h want %h", m_data1, exp1(-262144, 10)); end
    tests++; if (m_data2 !== exp2(262144, 10)) begin fails++; $display("[TB] FAIL wrap_wide: got %h want %h", m_data2, exp2(262144, 10)); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int nvalid;
    logic [COL*OW1-1:0] got;
    nvalid = 0;
    got = '0;
    m_ready = 1'b1;
    send(5, 6, 0, 0, 1'b1, 1'b1);
    send(1, 1, 0, 0, 1'b1, 1'b1);
    @(posedge clk); #1;
    tests++; if (m_valid1 !== 1'b1 || m_data1 !== exp1(23, 34)) begin fails++; $display("[TB] FAIL b2b_first: got %b/%h want 1/%h", m_valid1, m_data1, exp1(23, 34)); end
    @(posedge clk); #1;
    tests++; if (m_valid1 !== 1'b1 || m_data1 !== exp1(4, 6)) begin fails++; $display("[TB] FAIL b2b_second: got %b/%h want 1/%h", m_valid1, m_data1, exp1(4, 6)); end
    @(posedge clk); #1;
    tests++; if (m_valid1 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_drain: got %b want 0", m_valid1); end
    send(2, 2, 0, 0, 1'b1, 1'b0);
    send(5, 6, 0, 0, 1'b1, 1'b1);
    for (int n = 0; n < 6; n++) begin
      if (m_valid1) begin nvalid++; got = m_data1; end
      @(posedge clk); #1;
    end
    tests++; if (nvalid != 1) begin fails++; $display("[TB] FAIL restart_count: got %0d want 1", nvalid); end
    tests++; if (got !== exp1(23, 34)) begin fails++; $display("[TB] FAIL restart_data: got %h want %h", got, exp1(23, 34)); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    m_ready = 1'b0;
    send(5, 6, 0, 0, 1'b1, 1'b1);
    send(1, 1, 0, 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    tests++; if (m_valid1 !== 1'b1) begin fails++; $display("[TB] FAIL mid_pending: got %b want 1", m_valid1); end
    rst_n = 1'b0;
    #1;
    tests++; if (m_valid1 !== 1'b0) begin fails++; $display("[TB] FAIL mid_m_valid: got %b want 0", m_valid1); end
    tests++; if (s_ready1 !== 1'b1) begin fails++; $display("[TB] FAIL mid_s_ready: got %b want 1", s_ready1); end
    tests++; if (m_data1 !== '0) begin fails++; $display("[TB] FAIL mid_m_data: got %h want 0", m_data1); end
    tests++; if (w_busy1 !== 1'b0) begin fails++; $display("[TB] FAIL mid_w_busy: got %b want 0", w_busy1); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    load_weights(2'b01, 1, 2);
    load_weights(2'b10, 3, 4);
    send(1, 1, 0, 0, 1'b0, 1'b1);
    wait_valid(10, seen);
    tests++; if (!seen) begin fails++; $display("[TB] FAIL mid_after_timeout: got no m_valid want m_valid"); end
    tests++; if (m_data1 !== exp1(4, 6)) begin fails++; $display("[TB] FAIL mid_after: got %h want %h", m_data1, exp1(4, 6)); end
    tests++; if (m_data2 !== exp2(4, 6)) begin fails++; $display("[TB] FAIL mid_after2: got %h want %h", m_data2, exp2(4, 6)); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_first = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    s_ci1   = '0;
    s_ci2   = '0;
    w_data  = '0;
    w_load  = '0;
    test_reset();
    test_single();
    test_group();
    test_stall();
    test_wload_busy();
    test_relu_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
